core_writeback: RTL and testbench



---
 rtl/core_pkg.sv | 20 ++
 rtl/wb_load_align.sv | 25 ++
 rtl/core_writeback.sv | 157 +++++++++++++++
 tb/tb_core_writeback.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the i2d core writeback path.
package core_pkg;

  typedef enum logic {
    WB_SEL_ALU  = 1'b0,
    WB_SEL_LOAD = 1'b1
  } wb_sel_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational sub-word load alignment with zero/sign extension.
module wb_load_align
  import core_pkg::*;
(
  input  ld_size_t    size,
  input  logic        ld_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      LD_B:    data = {{24{ld_signed & byte_v[7]}}, byte_v};
      LD_H:    data = {{16{ld_signed & half_v[15]}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/core_writeback.sv
// Writeback stage: ALU/load register-file write, bypass value and load watchdog.
// Define WB_LOAD_EXT_EN to compile in sub-word load alignment and extension.
module core_writeback
  import core_pkg::*;
#(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  wb_sel_t     ex_wbsel,
  input  logic        ex_we,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  ld_size_t    ex_ld_size,
  input  logic        ex_ld_signed,
  input  logic [1:0]  ex_addr_lo,
  input  logic        lsu_rvalid,
  input  logic [31:0] lsu_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam int unsigned TW = $clog2(LOAD_TIMEOUT);

  wb_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_we_q, ld_we_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_err_q, wb_err_d;
  logic [31:0] load_data;

`ifdef WB_LOAD_EXT_EN
  ld_size_t    ld_size_q, ld_size_d;
  logic        ld_signed_q, ld_signed_d;
  logic [1:0]  ld_addr_q, ld_addr_d;

  wb_load_align u_align (
    .size      (ld_size_q),
    .ld_signed (ld_signed_q),
    .addr_lo   (ld_addr_q),
    .rdata     (lsu_rdata),
    .data      (load_data)
  );
`else
  // Without the extension path the raw word is written for every size.
  logic unused_ld_cfg;
  assign unused_ld_cfg = ^{ex_ld_size, ex_ld_signed, ex_addr_lo};
  assign load_data     = lsu_rdata;
`endif

  assign ex_ready = (state_q == WB_IDLE);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_data  = wb_data_q;
  assign wb_err   = wb_err_q;

  // Next-state, watchdog and output-register update.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ld_rd_d    = ld_rd_q;
    ld_we_d    = ld_we_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_data_d  = wb_data_q;
    wb_err_d   = 1'b0;
`ifdef WB_LOAD_EXT_EN
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    ld_addr_d   = ld_addr_q;
`endif
    case (state_q)
      WB_IDLE: begin
        if (ex_valid) begin
          if (ex_wbsel == WB_SEL_LOAD) begin
            ld_rd_d = ex_rd;
            ld_we_d = ex_we;
`ifdef WB_LOAD_EXT_EN
            ld_size_d   = ex_ld_size;
            ld_signed_d = ex_ld_signed;
            ld_addr_d   = ex_addr_lo;
`endif
            timer_d = '0;
            state_d = WB_WAIT;
          end else begin
            rf_we_d    = ex_we && (ex_rd != 5'd0);
            rf_waddr_d = ex_rd;
            rf_wdata_d = ex_result;
            if (rf_we_d) wb_data_d = ex_result;
          end
        end
      end
      WB_WAIT: begin
        // Data arriving in the timeout cycle takes priority over the error.
        if (lsu_rvalid) begin
          rf_we_d    = ld_we_q && (ld_rd_q != 5'd0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = load_data;
          if (rf_we_d) wb_data_d = load_data;
          state_d    = WB_IDLE;
        end else if (timer_q == TW'(LOAD_TIMEOUT - 1)) begin
          wb_err_d = 1'b1;
          state_d  = WB_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= WB_IDLE;
      timer_q    <= '0;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
`ifdef WB_LOAD_EXT_EN
      ld_size_q   <= LD_W;
      ld_signed_q <= 1'b0;
      ld_addr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ld_rd_q    <= ld_rd_d;
      ld_we_q    <= ld_we_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_data_q  <= wb_data_d;
      wb_err_q   <= wb_err_d;
`ifdef WB_LOAD_EXT_EN
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_addr_q   <= ld_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_core_writeback.sv
// Scoreboard bench for core_writeback: ALU and load writes, alignment, timeout, reset.
module tb_core_writeback;
  import core_pkg::*;

  localparam int unsigned LT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  wb_sel_t     ex_wbsel = WB_SEL_ALU;
  logic        ex_we = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  ld_size_t    ex_ld_size = LD_W;
  logic        ex_ld_signed = 1'b0;
  logic [1:0]  ex_addr_lo = '0;
  logic        lsu_rvalid = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_data;
  logic        wb_err;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] wbd;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_wbd  = '0;
  int          vectors = 0;
  int          miscompares = 0;

  core_writeback #(.LOAD_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_wbsel     (ex_wbsel),
    .ex_we        (ex_we),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .ex_ld_size   (ex_ld_size),
    .ex_ld_signed (ex_ld_signed),
    .ex_addr_lo   (ex_addr_lo),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rdata    (lsu_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_data      (wb_data),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] align_model(input ld_size_t sz, input logic sg,
                                              input logic [1:0] al, input logic [31:0] w);
`ifdef WB_LOAD_EXT_EN
    logic [31:0] sh;
    case (sz)
      LD_B: begin
        sh = w >> (8 * al);
        return (sg && sh[7]) ? {24'hFF_FFFF, sh[7:0]} : {24'h0, sh[7:0]};
      end
      LD_H: begin
        sh = w >> (al[1] ? 16 : 0);
        return (sg && sh[15]) ? {16'hFFFF, sh[15:0]} : {16'h0, sh[15:0]};
      end
      default: return w;
    endcase
`else
    logic unused_args;
    unused_args = ^{sz, sg, al};
    return w;
`endif
  endfunction

  task automatic push_write(input logic we, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    m_addr = rd;
    m_data = d;
    if (we && rd != 5'd0) m_wbd = d;
    e.we   = we && (rd != 5'd0);
    e.addr = rd;
    e.data = d;
    e.wbd  = m_wbd;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b we=%b err=%b a=%0d d=%h wb=%h, need rdy=1 and all zero",
               ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [4:0]  rds[2]  = '{5'd5, 5'd0};
    logic [31:0] ress[2] = '{32'h1234_5678, 32'hFFFF_FFFF};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      ex_valid = 1'b1; ex_wbsel = WB_SEL_ALU; ex_we = 1'b1;
      ex_rd = rds[i]; ex_result = ress[i];
      push_write(1'b1, rds[i], ress[i]);
      tick();
      ex_valid = 1'b0;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL alu_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, e.we, 1'b0, e.addr, e.data, e.wbd}) begin
          miscompares++;
          $display("FAIL alu_%0d: got we=%b err=%b a=%0d d=%h wb=%h, need we=%b err=0 a=%0d d=%h wb=%h",
                   i, rf_we, wb_err, rf_waddr, rf_wdata, wb_data, e.we, e.addr, e.data, e.wbd);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      ex_valid = 1'b1; ex_wbsel = WB_SEL_ALU;
      ex_we = 1'($urandom_range(0, 1)); ex_rd = 5'($urandom_range(0, 31)); ex_result = r;
      push_write(ex_we, ex_rd, r);
      tick();
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_%0d: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, e.we, 1'b0, e.addr, e.data, e.wbd}) begin
          miscompares++;
          $display("FAIL b2b_%0d: got we=%b err=%b a=%0d d=%h wb=%h, need we=%b err=0 a=%0d d=%h wb=%h",
                   i, rf_we, wb_err, rf_waddr, rf_wdata, wb_data, e.we, e.addr, e.data, e.wbd);
        end
      end
    end
    // A stray rvalid while idle must not write.
    ex_valid = 1'b0; lsu_rvalid = 1'b1; lsu_rdata = 32'hA5A5_5A5A;
    tick();
    lsu_rvalid = 1'b0;
    vectors++;
    if ({ex_ready, rf_we, wb_err, wb_data} !== {1'b1, 1'b0, 1'b0, m_wbd}) begin
      miscompares++;
      $display("FAIL idle_rvalid: got rdy=%b we=%b err=%b wb=%h, need rdy=1 we=0 err=0 wb=%h",
               ex_ready, rf_we, wb_err, wb_data, m_wbd);
    end
  endtask

  task automatic test_load(input string nm, input ld_size_t sz, input logic sg, input logic [1:0] al,
                           input logic [31:0] w, input logic [4:0] rd, input logic we, input int dly);
    exp_t e;
    ex_valid = 1'b1; ex_wbsel = WB_SEL_LOAD; ex_we = we; ex_rd = rd; ex_result = 32'hDEAD_BEEF;
    ex_ld_size = sz; ex_ld_signed = sg; ex_addr_lo = al;
    tick();
    // Garbage ALU request while waiting; the stage must neither accept it nor relatch.
    ex_wbsel = WB_SEL_ALU; ex_we = 1'b1; ex_rd = ~rd; ex_addr_lo = ~al; ex_ld_signed = ~sg;
    ex_ld_size = (sz == LD_W) ? LD_B : LD_W;
    for (int c = 0; c < dly; c++) begin
      if (c > 0) tick();
      vectors++;
      if ({ex_ready, rf_we, wb_err} !== 3'b000) begin
        miscompares++;
        $display("FAIL %s_wait%0d: got rdy=%b we=%b err=%b, need all 0", nm, c, ex_ready, rf_we, wb_err);
      end
    end
    ex_valid = 1'b0; lsu_rvalid = 1'b1; lsu_rdata = w;
    push_write(we, rd, align_model(sz, sg, al, w));
    tick();
    lsu_rvalid = 1'b0; lsu_rdata = $urandom;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, e.we, 1'b0, e.addr, e.data, e.wbd}) begin
        miscompares++;
        $display("FAIL %s: got rdy=%b we=%b err=%b a=%0d d=%h wb=%h, need rdy=1 we=%b err=0 a=%0d d=%h wb=%h",
                 nm, ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data, e.we, e.addr, e.data, e.wbd);
      end
    end
  endtask

  task automatic test_timeout();
    ex_valid = 1'b1; ex_wbsel = WB_SEL_LOAD; ex_we = 1'b1; ex_rd = 5'd12;
    ex_ld_size = LD_W; ex_ld_signed = 1'b0; ex_addr_lo = 2'd0;
    tick();
    ex_valid = 1'b0;
    for (int c = 0; c < int'(LT); c++) begin
      if (c > 0) tick();
      vectors++;
      if ({ex_ready, rf_we, wb_err} !== 3'b000) begin
        miscompares++;
        $display("FAIL timeout_wait%0d: got rdy=%b we=%b err=%b, need all 0", c, ex_ready, rf_we, wb_err);
      end
    end
    tick();
    vectors++;
    if ({ex_ready, rf_we, wb_err, wb_data} !== {1'b1, 1'b0, 1'b1, m_wbd}) begin
      miscompares++;
      $display("FAIL timeout_err: got rdy=%b we=%b err=%b wb=%h, need rdy=1 we=0 err=1 wb=%h",
               ex_ready, rf_we, wb_err, wb_data, m_wbd);
    end
    tick();
    vectors++;
    if ({ex_ready, rf_we, wb_err} !== 3'b100) begin
      miscompares++;
      $display("FAIL timeout_pulse: got rdy=%b we=%b err=%b, need rdy=1 we=0 err=0", ex_ready, rf_we, wb_err);
    end
  endtask

  task automatic test_reset_in_wait();
    ex_valid = 1'b1; ex_wbsel = WB_SEL_LOAD; ex_we = 1'b1; ex_rd = 5'd15;
    ex_ld_size = LD_W; ex_ld_signed = 1'b0; ex_addr_lo = 2'd0;
    tick();
    ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    #2;
    sb.delete();
    m_addr = '0; m_data = '0; m_wbd = '0;
    vectors++;
    if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL rst_async: got rdy=%b we=%b err=%b a=%0d d=%h wb=%h, need rdy=1 and all zero",
               ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data);
    end
    tick();
    rst = 1'b1;
    tick();
    lsu_rvalid = 1'b1; lsu_rdata = 32'hCAFE_F00D;
    tick();
    lsu_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      vectors++;
      if ({ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0}) begin
        miscompares++;
        $display("FAIL rst_late_rvalid%0d: got rdy=%b we=%b err=%b a=%0d d=%h wb=%h, need rdy=1 and all zero",
                 c, ex_ready, rf_we, wb_err, rf_waddr, rf_wdata, wb_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load("ldb_signed",   LD_B, 1'b1, 2'd2, 32'h0080_0000, 5'd7,  1'b1, 3);
    test_load("ldh_unsigned", LD_H, 1'b0, 2'd3, 32'hBEEF_0000, 5'd9,  1'b1, 1);
    test_load("ldh_signed",   LD_H, 1'b1, 2'd0, 32'h1234_8001, 5'd10, 1'b1, 2);
    test_load("ldb_unsigned", LD_B, 1'b0, 2'd1, 32'h0000_A500, 5'd11, 1'b1, 1);
    test_load("ldw",          LD_W, 1'b1, 2'd3, 32'h8765_4321, 5'd12, 1'b1, 2);
    test_load("ld_rd0",       LD_B, 1'b1, 2'd3, 32'hFF00_0000, 5'd0,  1'b1, 1);
    test_load("ld_we0",       LD_W, 1'b0, 2'd0, 32'h1111_2222, 5'd14, 1'b0, 1);
    test_load("ld_last_cycle", LD_W, 1'b0, 2'd0, 32'h0BAD_CAFE, 5'd13, 1'b1, int'(LT));
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, need normal completion");
    $fatal(1);
  end

endmodule
